// File: rtl/alu_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_pkg
//  Description : Shared constants for the ALU issue block: default data
//                width, ALU operation encodings and FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_issue_pkg;

    // Default data width of registers and ALU operands
    localparam int C_N = 16;

    // ALU operation encodings driven on o_alu_ctrl
    localparam logic [1:0] C_OP_SUMA    = 2'b00;
    localparam logic [1:0] C_OP_SHIFT_D = 2'b01;
    localparam logic [1:0] C_OP_RESTA   = 2'b10;
    localparam logic [1:0] C_OP_SHIFT_I = 2'b11;

    // Issue FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_banco_reg.sv
`default_nettype none
// ============================================================================
//  Module      : banco_reg
//  Description : Register file with one synchronous write port, two
//                combinational operand read ports and a combinational debug
//                read port. All registers clear on reset.
//  Revision    : 1.0  initial release
// ============================================================================
module banco_reg
    import alu_issue_pkg::*;
#(
    parameter  int N    = C_N,
    parameter  int NREG = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_wa,
    input  logic [N-1:0]  i_wd,
    input  logic [AW-1:0] i_ra0,
    input  logic [AW-1:0] i_ra1,
    input  logic [AW-1:0] i_dbg_sel,
    output logic [N-1:0]  o_rd0,
    output logic [N-1:0]  o_rd1,
    output logic [N-1:0]  o_dbg_data
);

    logic [N-1:0] r_mem [NREG];

    // Register storage: async clear, write on the rising edge when enabled
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_rd0      = r_mem[i_ra0];
    assign o_rd1      = r_mem[i_ra1];
    assign o_dbg_data = r_mem[i_dbg_sel];

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue
//  Description : Single-issue sequencer for an external combinational ALU.
//                Accepts load-immediate or ALU instructions, reads operands,
//                presents them to the ALU, latches the result and flags and
//                writes the destination register.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter  int N    = C_N,
    parameter  int NREG = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic          i_ld,
    input  logic [N-1:0]  i_imm,
    input  logic [1:0]    i_op,
    input  logic [AW-1:0] i_rd,
    input  logic [AW-1:0] i_ra,
    input  logic [AW-1:0] i_rb,
    output logic [N-1:0]  o_alu_a,
    output logic [N-1:0]  o_alu_b,
    output logic [1:0]    o_alu_ctrl,
    input  logic [N-1:0]  i_alu_q,
    input  logic          i_alu_mayor,
    input  logic          i_alu_paridad,
    output logic          o_mayor,
    output logic          o_paridad,
    output logic          o_done,
    input  logic [AW-1:0] i_dbg_sel,
    output logic [N-1:0]  o_dbg_data
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_ready;
    logic          w_done;
    logic          w_we;

    // Captured instruction fields
    logic          r_ld;
    logic [N-1:0]  r_imm;
    logic [1:0]    r_op;
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_ra;
    logic [AW-1:0] r_rb;

    // Operand latches; these drive the ALU directly so its inputs only
    // change on the edge entering EXEC and otherwise hold steady
    logic [N-1:0]  r_opa;
    logic [N-1:0]  r_opb;
    logic [1:0]    r_ctrl;

    // ALU result captured leaving EXEC, committed in WRITE
    logic [N-1:0]  r_q;
    logic          r_res_mayor;
    logic          r_res_paridad;
    logic          r_mayor;
    logic          r_paridad;

    logic [N-1:0]  w_rda;
    logic [N-1:0]  w_rdb;
    logic [N-1:0]  w_wd;

    assign w_wd = r_ld ? r_imm : r_q;

    banco_reg #(
        .N    (N),
        .NREG (NREG)
    ) u_banco_reg (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_we       (w_we),
        .i_wa       (r_rd),
        .i_wd       (w_wd),
        .i_ra0      (r_ra),
        .i_ra1      (r_rb),
        .i_dbg_sel  (i_dbg_sel),
        .o_rd0      (w_rda),
        .o_rd1      (w_rdb),
        .o_dbg_data (o_dbg_data)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state control outputs
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        w_we        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (i_valid) begin
                    w_state_nxt = i_ld ? ST_WRITE : ST_READ;
                end
            end
            ST_READ:  w_state_nxt = ST_EXEC;
            ST_EXEC:  w_state_nxt = ST_WRITE;
            ST_WRITE: begin
                w_done      = 1'b1;
                w_we        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: capture, operand read, result latch and flag commit
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ld          <= 1'b0;
            r_imm         <= '0;
            r_op          <= '0;
            r_rd          <= '0;
            r_ra          <= '0;
            r_rb          <= '0;
            r_opa         <= '0;
            r_opb         <= '0;
            r_ctrl        <= '0;
            r_q           <= '0;
            r_res_mayor   <= 1'b0;
            r_res_paridad <= 1'b0;
            r_mayor       <= 1'b0;
            r_paridad     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_ld  <= i_ld;
                        r_imm <= i_imm;
                        r_op  <= i_op;
                        r_rd  <= i_rd;
                        r_ra  <= i_ra;
                        r_rb  <= i_rb;
                    end
                end
                ST_READ: begin
                    r_opa  <= w_rda;
                    r_opb  <= w_rdb;
                    r_ctrl <= r_op;
                end
                ST_EXEC: begin
                    r_q           <= i_alu_q;
                    r_res_mayor   <= i_alu_mayor;
                    r_res_paridad <= i_alu_paridad;
                end
                ST_WRITE: begin
                    // Loads leave the flags of the previous ALU operation
                    if (!r_ld) begin
                        r_mayor   <= r_res_mayor;
                        r_paridad <= r_res_paridad;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ready    = w_ready;
    assign o_done     = w_done;
    assign o_alu_a    = r_opa;
    assign o_alu_b    = r_opb;
    assign o_alu_ctrl = r_ctrl;
    assign o_mayor    = r_mayor;
    assign o_paridad  = r_paridad;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue
//  Description : Self-checking bench for alu_issue with a behavioural ALU at
//                the parent level and a scoreboard of expected retirements.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_issue;

    localparam logic [1:0] OP_SUMA    = 2'b00;
    localparam logic [1:0] OP_SHIFT_D = 2'b01;
    localparam logic [1:0] OP_RESTA   = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ready;
    logic        ld;
    logic [15:0] imm;
    logic [1:0]  op;
    logic [2:0]  rd, ra, rb;
    logic [15:0] alu_a, alu_b, alu_q;
    logic [1:0]  alu_ctrl;
    logic        alu_mayor, alu_par;
    logic        mayor, paridad, done;
    logic [2:0]  dbg_sel;
    logic [15:0] dbg_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] val;
        logic        mayor;
        logic        par;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mreg [8];
    logic        m_mayor, m_par;

    always #5 clk = ~clk;

    // Reference ALU: carry/borrow or shifted-out bit as mayor, LSB as paridad
    function automatic logic [17:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] f);
        logic [16:0] t;
        logic        m;
        case (f)
            2'b00:   begin t = {1'b0, a} + {1'b0, b}; m = t[16]; end
            2'b10:   begin t = {1'b0, a} - {1'b0, b}; m = t[16]; end
            2'b01:   begin t = {1'b0, a >> 1};        m = a[0];  end
            default: begin t = {1'b0, a << 1};        m = a[15]; end
        endcase
        return {m, t[0], t[15:0]};
    endfunction

    assign {alu_mayor, alu_par, alu_q} = alu_ref(alu_a, alu_b, alu_ctrl);

    alu_issue #(.N(16), .NREG(8)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_valid       (valid),
        .o_ready       (ready),
        .i_ld          (ld),
        .i_imm         (imm),
        .i_op          (op),
        .i_rd          (rd),
        .i_ra          (ra),
        .i_rb          (rb),
        .o_alu_a       (alu_a),
        .o_alu_b       (alu_b),
        .o_alu_ctrl    (alu_ctrl),
        .i_alu_q       (alu_q),
        .i_alu_mayor   (alu_mayor),
        .i_alu_paridad (alu_par),
        .o_mayor       (mayor),
        .o_paridad     (paridad),
        .o_done        (done),
        .i_dbg_sel     (dbg_sel),
        .o_dbg_data    (dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model the instruction and push its expected retirement
    task automatic predict(input logic l, input logic [15:0] im, input logic [1:0] f,
                           input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
        exp_t        e;
        logic [17:0] r;
        if (l) begin
            e.val = im;
        end else begin
            r       = alu_ref(mreg[a], mreg[b], f);
            e.val   = r[15:0];
            m_mayor = r[17];
            m_par   = r[16];
        end
        e.rd    = d;
        e.mayor = m_mayor;
        e.par   = m_par;
        mreg[d] = e.val;
        sb.push_back(e);
    endtask

    // Called on the cycle after o_done: register and flags must be updated
    task automatic retire_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            dbg_sel = e.rd;
            #1;
            chk("wr_data", dbg_data, e.val);
            chk("mayor", mayor, e.mayor);
            chk("paridad", paridad, e.par);
        end
    endtask

    task automatic peek(input string tag, input logic [2:0] r, input logic [15:0] v);
        dbg_sel = r;
        #1;
        chk(tag, dbg_data, v);
    endtask

    task automatic issue(input logic l, input logic [15:0] im, input logic [1:0] f,
                         input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
        int n;
        @(negedge clk);
        chk("ready_idle", ready, 1);
        ld = l; imm = im; op = f; rd = d; ra = a; rb = b;
        valid = 1'b1;
        predict(l, im, f, d, a, b);
        @(posedge clk); #1;
        valid = 1'b0;
        n = 0;
        while (!done && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, l ? 0 : 2);
        chk("ready_busy", ready, 0);
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
        retire_check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, dones, busy;
        logic pend;
        for (int i = 0; i < 8; i++) mreg[i] = '0;
        m_mayor = 1'b0; m_par = 1'b0;
        rst = 1'b1; valid = 1'b0; ld = 1'b0; imm = '0; op = '0;
        rd = '0; ra = '0; rb = '0; dbg_sel = '0;

        // Reset state
        #3;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_flags", {mayor, paridad}, 0);
        chk("rst_alu", {alu_a, alu_b, alu_ctrl}, 0);
        chk("rst_dbg", dbg_data, 0);
        #19 rst = 1'b0;

        // Suma with carry out
        issue(1, 16'hFFFF, OP_SUMA, 1, 0, 0);
        issue(1, 16'h0001, OP_SUMA, 2, 0, 0);
        issue(0, 16'h0000, OP_SUMA, 3, 1, 2);
        peek("suma_r3", 3, 16'h0000);
        chk("suma_mayor", mayor, 1);
        chk("suma_par", paridad, 0);

        // Resta with rd == ra
        issue(1, 16'h0005, OP_SUMA, 1, 0, 0);
        issue(1, 16'h0003, OP_SUMA, 2, 0, 0);
        issue(0, 16'h0000, OP_RESTA, 1, 1, 2);
        peek("resta_r1", 1, 16'h0002);
        chk("resta_mayor", mayor, 0);
        chk("resta_par", paridad, 0);

        // Right shift, then a load into reg0 must keep the flags
        issue(1, 16'h0003, OP_SUMA, 4, 0, 0);
        issue(0, 16'h0000, OP_SHIFT_D, 5, 4, 0);
        peek("shd_r5", 5, 16'h0001);
        chk("shd_par", paridad, 1);
        issue(1, 16'h7777, OP_SUMA, 0, 0, 0);
        chk("ld_keeps_par", paridad, 1);
        peek("r0_write", 0, 16'h7777);

        // Load immediate into the top register
        issue(1, 16'hA5A5, OP_SUMA, 7, 0, 0);
        peek("ld_r7", 7, 16'hA5A5);

        // Valid held high: accumulate reg1 += reg2, one accept per 4 cycles
        acc = 0; dones = 0; busy = 0; pend = 1'b0;
        dbg_sel = 3'd1;
        @(negedge clk);
        ld = 1'b0; op = OP_SUMA; rd = 3'd1; ra = 3'd1; rb = 3'd2;
        valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            if (ready) begin
                acc++;
                predict(0, 16'h0000, OP_SUMA, 1, 1, 2);
            end else begin
                busy++;
            end
            @(posedge clk); #1;
            if (pend) begin
                retire_check();
                pend = 1'b0;
            end
            if (done) begin
                dones++;
                pend = 1'b1;
            end
        end
        valid = 1'b0;
        chk("stream_accepts", acc, 4);
        chk("stream_dones", dones, 4);
        chk("stream_busy", busy, 12);
        peek("stream_r1", 1, 16'h000E);

        // Reset during EXEC of a suma into reg6
        issue(1, 16'hFFFF, OP_SUMA, 1, 0, 0);
        issue(0, 16'h0000, OP_SUMA, 3, 1, 2);
        chk("pre_rst_mayor", mayor, 1);
        issue(1, 16'h1234, OP_SUMA, 6, 0, 0);
        @(negedge clk);
        ld = 1'b0; op = OP_SUMA; rd = 3'd6; ra = 3'd6; rb = 3'd2;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk); #1;
        chk("in_exec_ctrl", alu_ctrl, OP_SUMA);
        chk("in_exec_a", alu_a, 16'h1234);
        rst = 1'b1;
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        chk("abort_flags", {mayor, paridad}, 0);
        chk("abort_alu", {alu_a, alu_b, alu_ctrl}, 0);
        peek("abort_r6", 6, 16'h0000);
        @(posedge clk); #1;
        chk("abort_done_hold", done, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mreg[i] = '0;
        m_mayor = 1'b0; m_par = 1'b0;

        // First edge after reset accepts
        issue(1, 16'h00FF, OP_SUMA, 6, 0, 0);
        for (int i = 0; i < 8; i++) begin
            peek("final_reg", i[2:0], mreg[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter N, default 16, data width of registers and ALU operands.
REQ-002 Parameter NREG, default 8, number of general registers; AW = clog2(NREG) is derived, not a parameter.
REQ-003 i_clk  in  1  single clock; all state changes on rising edge.
REQ-004 i_reset  in  1  reset, asynchronous and active-high.
REQ-005 i_valid  in  1  instruction present; o_ready  out  1  block can accept an instruction.
REQ-006 i_ld  in  1  1 = load immediate, 0 = ALU operation; i_imm  in  N  immediate value.
REQ-007 i_op  in  2  ALU operation: suma 00, shift_d 01, resta 10, shift_i 11.
REQ-008 i_rd, i_ra, i_rb  in  AW each  destination, operand-A and operand-B register indices.
REQ-009 o_alu_a, o_alu_b  out  N each; o_alu_ctrl  out  2; all three drive the ALU inputs.
REQ-010 i_alu_q  in  N; i_alu_mayor  in  1; i_alu_paridad  in  1; all three are the ALU results.
REQ-011 o_mayor, o_paridad  out  1 each  latched flags of the last completed ALU operation.
REQ-012 o_done  out  1  one-cycle pulse when an instruction retires.
REQ-013 i_dbg_sel  in  AW; o_dbg_data  out  N  combinational register read for debug.

Function
REQ-014 The FSM SHALL have the states IDLE, READ, EXEC and WRITE; o_ready = 1 only in IDLE.
REQ-015 In IDLE with i_valid=1, the block SHALL capture i_ld, i_imm, i_op, i_rd, i_ra and i_rb on the edge.
- i_ld=1 -> WRITE.
- i_ld=0 -> READ.
REQ-016 READ SHALL latch reg[ra] and reg[rb] into operand registers, then go to EXEC.
REQ-017 EXEC SHALL drive o_alu_a/o_alu_b from the operand registers and o_alu_ctrl from the captured op, then latch i_alu_q, i_alu_mayor and i_alu_paridad at the edge leaving EXEC, then go to WRITE.
REQ-018 WRITE SHALL write the result (ALU result or immediate) to reg[rd] and assert o_done for exactly this cycle, then return to IDLE.
REQ-019 For an ALU instruction, WRITE SHALL also update o_mayor/o_paridad; a load SHALL leave the flags unchanged.
REQ-020 Latency: an ALU instruction accepted at edge k SHALL have o_done=1 during the cycle after edge k+2; a load SHALL have o_done=1 during the cycle after edge k.
REQ-021 Outside EXEC, o_alu_a, o_alu_b and o_alu_ctrl SHALL hold their last values (no glitch-driven toggling); the ALU is treated as purely combinational within one cycle.
REQ-022 The block SHALL not modify i_alu_q; the result is written at N bits with no extension or truncation.
REQ-023 rd = ra and/or rd = rb SHALL be legal; operands are the values before the write.
REQ-024 i_valid while busy SHALL be ignored (no queuing); the upstream holds the instruction until o_ready=1.
REQ-025 Register 0 SHALL be an ordinary writable register.
REQ-026 o_dbg_data SHALL reflect a WRITE on the cycle after the write edge.

Reset
REQ-027 While i_reset=1, regardless of clock:
- state = IDLE;
- all registers, operand latches and captured fields = 0;
- o_mayor = o_paridad = o_done = 0;
- o_alu_a = o_alu_b = 0, o_alu_ctrl = 00;
- o_ready = 1.
REQ-028 Reset during READ/EXEC/WRITE SHALL abort the instruction with no register or flag write and no o_done.
REQ-029 After reset deasserts, the first rising edge SHALL be able to accept an instruction.

Structure
REQ-030 A shared package SHALL hold N, the op encodings (suma, resta, shift_d, shift_i) and the FSM state encoding.
REQ-031 The register file SHALL be a sub-module banco_reg, with two synchronous-write/combinational-read ports plus the debug read port, reset to 0.
REQ-032 The ALU SHALL be instantiated outside alu_issue, at the parent level.

Verification
REQ-033 Load reg1 = 0xFFFF, load reg2 = 0x0001, suma rd=3 ra=1 rb=2 -> reg3 = 0x0000, o_mayor = 1, o_paridad = 0, o_done 3 cycles after accept.
REQ-034 reg1 = 0x0005, reg2 = 0x0003, resta rd=1 ra=1 rb=2 -> reg1 = 0x0002, o_mayor = 0, o_paridad = 0.
REQ-035 reg4 = 0x0003, shift_d rd=5 ra=4 -> reg5 = 0x0001, o_paridad = 1; a following load leaves o_paridad = 1.
REQ-036 i_valid held high continuously -> o_ready = 0 in READ/EXEC/WRITE, exactly one accept per 4 cycles, no duplicate writes.
REQ-037 Assert i_reset during EXEC of suma into reg6 (preloaded 0x1234) -> reg6 = 0, flags = 0, no o_done, o_ready = 1 immediately.
REQ-038 Load-immediate 0xA5A5 into reg7 -> o_done on the cycle after accept, o_dbg_data(sel=7) = 0xA5A5 on the next cycle.
